// File: rtl/rs232_pkg.sv
// Shared RS232 register map and image-upload FSM states.
// The RS232 receive path imports the same constants.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    POLL,
    SEND,
    DONE
  } state_t;

  localparam logic [19:0] NUM_WORDS_MAX = 20'hFFFFF;
  localparam logic [4:0]  RX_ADDR       = 5'd0;
  localparam logic [4:0]  TX_ADDR       = 5'd4;
  localparam logic [4:0]  STATUS_ADDR   = 5'd8;
  localparam int unsigned TX_OK_BIT     = 6;
  localparam int unsigned RX_OK_BIT     = 7;

endpackage

// File: rtl/image_transmitter.sv
// Streams 16-bit SRAM words out over the RS232 Avalon-MM core, high byte first,
// polling the TX-ready status bit before every byte.
module image_transmitter
  import rs232_pkg::*;
(
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic        i_start,
  input  logic [19:0] i_num_words,
  output logic [19:0] o_sram_addr,
  output logic        o_sram_rd,
  input  logic [15:0] i_sram_data,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        o_busy,
  output logic        o_finished
);

  state_t      state, state_n;
  logic [19:0] addr_n;
  logic [19:0] count, count_n;
  logic [15:0] word, word_n;
  logic        byte_hi, byte_hi_n;
  logic [7:0]  tx_byte;
  logic        last_word;
  logic        unused_status_bits;

  // Only the TX-ready bit of the status word matters here.
  assign unused_status_bits = ^{avm_readdata[31:TX_OK_BIT+1], avm_readdata[TX_OK_BIT-1:0]};

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state       <= IDLE;
      o_sram_addr <= '0;
      word        <= '0;
      byte_hi     <= 1'b1;
      count       <= '0;
    end else begin
      state       <= state_n;
      o_sram_addr <= addr_n;
      word        <= word_n;
      byte_hi     <= byte_hi_n;
      count       <= count_n;
    end
  end

  always_comb begin
    state_n       = state;
    addr_n        = o_sram_addr;
    word_n        = word;
    byte_hi_n     = byte_hi;
    count_n       = count;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    o_sram_rd     = 1'b0;
    o_busy        = (state != IDLE);
    o_finished    = 1'b0;
    tx_byte       = byte_hi ? word[15:8] : word[7:0];
    // count is never 0 outside IDLE, so count-1 cannot underflow where used.
    last_word     = (o_sram_addr == count - 20'd1);

    case (state)
      IDLE: begin
        if (i_start) begin
          if (i_num_words != '0) begin
            count_n = i_num_words;
            addr_n  = '0;
            state_n = RD;
          end else begin
            state_n = DONE;
          end
        end
      end
      RD: begin
        o_sram_rd = 1'b1;
        word_n    = i_sram_data;
        byte_hi_n = 1'b1;
        state_n   = POLL;
      end
      POLL: begin
        o_sram_rd   = 1'b1;
        avm_read    = 1'b1;
        avm_address = STATUS_ADDR;
        if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
          state_n = SEND;
        end
      end
      SEND: begin
        o_sram_rd     = 1'b1;
        avm_write     = 1'b1;
        avm_address   = TX_ADDR;
        avm_writedata = {24'd0, tx_byte};
        if (!avm_waitrequest) begin
          if (byte_hi) begin
            byte_hi_n = 1'b0;
            state_n   = POLL;
          end else if (last_word) begin
            state_n = DONE;
          end else begin
            addr_n  = o_sram_addr + 20'd1;
            state_n = RD;
          end
        end
      end
      DONE: begin
        o_finished = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_image_transmitter.sv
// Directed bench for image_transmitter: SRAM array model plus an Avalon RS232
// slave with programmable not-ready status reads and write stalls.
module tb_image_transmitter;
  import rs232_pkg::*;

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic        i_start;
  logic [19:0] i_num_words;
  logic [19:0] o_sram_addr;
  logic        o_sram_rd;
  logic [15:0] i_sram_data;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        o_busy;
  logic        o_finished;

  logic [15:0] mem [0:15];
  logic [7:0]  tx_log [$];
  int          wr_reads [$];
  int          vec = 0;
  int          err = 0;
  int          nr_target = 0;
  int          nr_done = 0;
  int          stall_target = 0;
  int          stall_done = 0;
  int          status_reads = 0;
  int          fin_cnt = 0;
  int          both_hi = 0;
  int          bad_bus = 0;
  logic        last_ok = 1'b0;

  always #5 avm_clk = ~avm_clk;

  image_transmitter dut (
    .avm_clk        (avm_clk),
    .avm_rst        (avm_rst),
    .i_start        (i_start),
    .i_num_words    (i_num_words),
    .o_sram_addr    (o_sram_addr),
    .o_sram_rd      (o_sram_rd),
    .i_sram_data    (i_sram_data),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .o_busy         (o_busy),
    .o_finished     (o_finished)
  );

  assign i_sram_data     = mem[o_sram_addr[3:0]];
  assign avm_readdata    = {25'd0, (nr_done >= nr_target), 6'd0};
  assign avm_waitrequest = avm_write && (stall_done < stall_target);

  // Slave model / bus monitor; counters that feed DUT inputs update with <=.
  always @(posedge avm_clk) begin
    if (avm_read && avm_write) both_hi++;
    if (avm_read && avm_address !== STATUS_ADDR) bad_bus++;
    if (avm_read && !avm_waitrequest) begin
      status_reads++;
      last_ok = avm_readdata[6];
      if (!avm_readdata[6]) nr_done <= nr_done + 1;
    end
    if (avm_write) begin
      if (avm_waitrequest) begin
        stall_done <= stall_done + 1;
      end else begin
        tx_log.push_back(avm_writedata[7:0]);
        wr_reads.push_back(status_reads);
        if (!last_ok || avm_address !== TX_ADDR || avm_writedata[31:8] !== 24'd0) bad_bus++;
        last_ok = 1'b0;
      end
    end
    if (o_finished) fin_cnt++;
  end

  task automatic start_upload(input logic [19:0] n);
    @(negedge avm_clk);
    i_start     = 1'b1;
    i_num_words = n;
    @(negedge avm_clk);
    i_start     = 1'b0;
  endtask

  task automatic wait_fin(output int cyc);
    cyc = 0;
    while (!o_finished && cyc < 200) begin
      @(negedge avm_clk);
      cyc++;
    end
    if (!o_finished) cyc = -1;
  endtask

  task automatic test_reset;
    avm_rst = 1'b1;
    #1;
    vec++; if ({avm_read, avm_write, o_sram_rd, o_busy, o_finished} !== 5'b0) begin err++; $display("FAIL rst_strobes: got %b want 00000", {avm_read, avm_write, o_sram_rd, o_busy, o_finished}); end
    vec++; if (avm_address !== 5'd0) begin err++; $display("FAIL rst_address: got %0h want 0", avm_address); end
    vec++; if (avm_writedata !== 32'd0) begin err++; $display("FAIL rst_writedata: got %0h want 0", avm_writedata); end
    vec++; if (o_sram_addr !== 20'd0) begin err++; $display("FAIL rst_sram_addr: got %0h want 0", o_sram_addr); end
    repeat (2) @(negedge avm_clk);
    avm_rst = 1'b0;
    repeat (2) @(negedge avm_clk);
    vec++; if (o_busy !== 1'b0) begin err++; $display("FAIL rst_idle_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_basic;
    int c, b, f0;
    logic [7:0] exp [4];
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    mem[0] = 16'hA1B2;
    mem[1] = 16'hC3D4;
    b  = tx_log.size();
    f0 = fin_cnt;
    start_upload(20'd2);
    vec++; if ({o_sram_rd, o_busy, avm_read, avm_write} !== 4'b1100) begin err++; $display("FAIL basic_rd_state: got %b want 1100", {o_sram_rd, o_busy, avm_read, avm_write}); end
    vec++; if (o_sram_addr !== 20'd0) begin err++; $display("FAIL basic_first_addr: got %0h want 0", o_sram_addr); end
    wait_fin(c);
    vec++; if (c != 10) begin err++; $display("FAIL basic_latency: got %0d want 10", c); end
    vec++; if (o_busy !== 1'b1) begin err++; $display("FAIL basic_done_busy: got %b want 1", o_busy); end
    @(negedge avm_clk);
    vec++; if ({o_finished, o_busy} !== 2'b00) begin err++; $display("FAIL basic_after_done: got %b want 00", {o_finished, o_busy}); end
    vec++; if (tx_log.size() - b != 4) begin err++; $display("FAIL basic_nbytes: got %0d want 4", tx_log.size() - b); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (tx_log[b+i] !== exp[i]) begin err++; $display("FAIL basic_byte%0d: got %0h want %0h", i, tx_log[b+i], exp[i]); end
    end
    repeat (3) @(negedge avm_clk);
    vec++; if (fin_cnt - f0 != 1) begin err++; $display("FAIL basic_fin_pulses: got %0d want 1", fin_cnt - f0); end
  endtask

  task automatic test_backpressure;
    int c, b, r0;
    mem[0] = 16'h5A3C;
    b  = tx_log.size();
    r0 = status_reads;
    nr_target = nr_target + 5;
    start_upload(20'd1);
    wait_fin(c);
    vec++; if (c != 10) begin err++; $display("FAIL bp_latency: got %0d want 10", c); end
    vec++; if (wr_reads[b] - r0 != 6) begin err++; $display("FAIL bp_reads_before_write: got %0d want 6", wr_reads[b] - r0); end
    vec++; if (tx_log.size() - b != 2) begin err++; $display("FAIL bp_nbytes: got %0d want 2", tx_log.size() - b); end
    vec++; if (tx_log[b] !== 8'h5A || tx_log[b+1] !== 8'h3C) begin err++; $display("FAIL bp_bytes: got %0h %0h want 5a 3c", tx_log[b], tx_log[b+1]); end
  endtask

  task automatic test_stall;
    int c, b, k;
    mem[0] = 16'h9E17;
    b = tx_log.size();
    stall_target = stall_target + 3;
    start_upload(20'd1);
    k = 0;
    while (!avm_write && k < 50) begin
      @(negedge avm_clk);
      k++;
    end
    for (int i = 0; i < 4; i++) begin
      vec++; if ({avm_write, avm_address, avm_writedata} !== {1'b1, 5'd4, 32'h9E}) begin err++; $display("FAIL stall_cycle%0d: got w=%b a=%0h d=%0h want w=1 a=4 d=9e", i, avm_write, avm_address, avm_writedata); end
      @(negedge avm_clk);
    end
    vec++; if ({avm_read, avm_write} !== 2'b10) begin err++; $display("FAIL stall_release: got %b want 10", {avm_read, avm_write}); end
    wait_fin(c);
    vec++; if (tx_log.size() - b != 2) begin err++; $display("FAIL stall_nbytes: got %0d want 2", tx_log.size() - b); end
    vec++; if (tx_log[b] !== 8'h9E || tx_log[b+1] !== 8'h17) begin err++; $display("FAIL stall_bytes: got %0h %0h want 9e 17", tx_log[b], tx_log[b+1]); end
  endtask

  task automatic test_zero_len;
    int b, r0;
    b  = tx_log.size();
    r0 = status_reads;
    start_upload(20'd0);
    vec++; if ({o_finished, o_busy, avm_read, avm_write} !== 4'b1100) begin err++; $display("FAIL zero_done: got %b want 1100", {o_finished, o_busy, avm_read, avm_write}); end
    @(negedge avm_clk);
    vec++; if ({o_finished, o_busy} !== 2'b00) begin err++; $display("FAIL zero_idle: got %b want 00", {o_finished, o_busy}); end
    vec++; if (status_reads != r0 || tx_log.size() != b) begin err++; $display("FAIL zero_no_access: got reads=%0d writes=%0d want 0 0", status_reads - r0, tx_log.size() - b); end
  endtask

  task automatic test_start_ignored;
    int c, b;
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    mem[0] = 16'h1122;
    mem[1] = 16'h3344;
    b = tx_log.size();
    start_upload(20'd2);
    @(negedge avm_clk);
    i_start     = 1'b1;
    i_num_words = 20'd1;
    @(negedge avm_clk);
    i_start     = 1'b0;
    vec++; if (o_sram_addr !== 20'd0) begin err++; $display("FAIL ign_addr: got %0h want 0", o_sram_addr); end
    wait_fin(c);
    vec++; if (c != 8) begin err++; $display("FAIL ign_latency: got %0d want 8", c); end
    vec++; if (tx_log.size() - b != 4) begin err++; $display("FAIL ign_nbytes: got %0d want 4", tx_log.size() - b); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (tx_log[b+i] !== exp[i]) begin err++; $display("FAIL ign_byte%0d: got %0h want %0h", i, tx_log[b+i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int c, b;
    mem[0] = 16'hABCD;
    start_upload(20'd1);
    wait_fin(c);
    @(negedge avm_clk);
    vec++; if (o_busy !== 1'b0) begin err++; $display("FAIL b2b_idle: got %b want 0", o_busy); end
    b = tx_log.size();
    i_start     = 1'b1;
    i_num_words = 20'd1;
    @(negedge avm_clk);
    i_start     = 1'b0;
    vec++; if ({o_sram_rd, o_sram_addr} !== {1'b1, 20'd0}) begin err++; $display("FAIL b2b_restart: got rd=%b addr=%0h want rd=1 addr=0", o_sram_rd, o_sram_addr); end
    wait_fin(c);
    vec++; if (c != 5) begin err++; $display("FAIL b2b_latency: got %0d want 5", c); end
    vec++; if (tx_log.size() - b != 2 || tx_log[b] !== 8'hAB || tx_log[b+1] !== 8'hCD) begin err++; $display("FAIL b2b_bytes: got n=%0d %0h %0h want n=2 ab cd", tx_log.size() - b, tx_log[b], tx_log[b+1]); end
  endtask

  task automatic test_reset_mid;
    int c, b, k;
    mem[0] = 16'h1020; mem[1] = 16'h3040; mem[2] = 16'h5060;
    mem[3] = 16'h7080; mem[4] = 16'h90A0;
    start_upload(20'd5);
    k = 0;
    while (!(avm_write && o_sram_addr == 20'd3) && k < 200) begin
      @(negedge avm_clk);
      k++;
    end
    vec++; if (k >= 200) begin err++; $display("FAIL rmid_reach_word3: got timeout want SEND of word 3"); end
    b = tx_log.size();
    #2 avm_rst = 1'b1;
    #1;
    vec++; if ({avm_read, avm_write, o_sram_rd, o_busy, o_finished} !== 5'b0) begin err++; $display("FAIL rmid_strobes: got %b want 00000", {avm_read, avm_write, o_sram_rd, o_busy, o_finished}); end
    vec++; if ({avm_address, avm_writedata, o_sram_addr} !== 57'd0) begin err++; $display("FAIL rmid_buses: got a=%0h d=%0h s=%0h want 0 0 0", avm_address, avm_writedata, o_sram_addr); end
    repeat (2) @(negedge avm_clk);
    avm_rst = 1'b0;
    repeat (2) @(negedge avm_clk);
    vec++; if (o_busy !== 1'b0 || tx_log.size() != b) begin err++; $display("FAIL rmid_abandon: got busy=%b extra=%0d want busy=0 extra=0", o_busy, tx_log.size() - b); end
    start_upload(20'd1);
    vec++; if ({o_sram_rd, o_sram_addr} !== {1'b1, 20'd0}) begin err++; $display("FAIL rmid_restart: got rd=%b addr=%0h want rd=1 addr=0", o_sram_rd, o_sram_addr); end
    wait_fin(c);
    vec++; if (tx_log.size() - b != 2 || tx_log[b] !== 8'h10 || tx_log[b+1] !== 8'h20) begin err++; $display("FAIL rmid_bytes: got n=%0d %0h %0h want n=2 10 20", tx_log.size() - b, tx_log[b], tx_log[b+1]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    avm_rst     = 1'b1;
    i_start     = 1'b0;
    i_num_words = '0;
    test_reset;
    test_basic;
    test_backpressure;
    test_stall;
    test_zero_len;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    vec++; if (both_hi != 0) begin err++; $display("FAIL read_write_overlap: got %0d want 0", both_hi); end
    vec++; if (bad_bus != 0) begin err++; $display("FAIL bus_protocol: got %0d bad cycles want 0", bad_bus); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
